// File: rtl/dsp_mac_pipe_if.sv
// Request/result bus of the MAC engine: valid/ready request channel and
// first-word-fall-through result channel.
interface dsp_mac_pipe_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_ACC = 32
);
  localparam int IDW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [2*WIDTH-1:0]   in_c;
  logic [1:0]           in_mode;
  logic [IDW-1:0]       in_id;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_result;
  logic [WIDTH-1:0]     out_q;
  logic [IDW-1:0]       out_id;

  // Requester / result consumer side
  modport master (
    output in_valid, in_a, in_b, in_c, in_mode, in_id, out_ready,
    input  in_ready, out_valid, out_result, out_q, out_id
  );

  // MAC engine side
  modport slave (
    input  in_valid, in_a, in_b, in_c, in_mode, in_id, out_ready,
    output in_ready, out_valid, out_result, out_q, out_id
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Four-stage pipelined signed MAC engine (MUL / MULADD / per-ID MAC / CLR)
// with an in-order output FIFO and credit-based request backpressure.
module dsp_mac_pipe #(
  parameter int WIDTH     = 16,
  parameter int FRAC      = 8,
  parameter int NUM_ACC   = 32,
  parameter int OUT_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  dsp_mac_pipe_if.slave bus,
  output logic [2:0]    inflight,
  output logic [31:0]   perf_ops
);
  localparam int W2  = 2 * WIDTH;
  localparam int IDW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int PW  = $clog2(OUT_DEPTH);
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [W2:0] RND_C =
    (FRAC > 0) ? ({{W2{1'b0}}, 1'b1} << RND_SH) : {(W2+1){1'b0}};
  localparam logic signed [W2:0] MAX_Q = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [W2:0] MIN_Q = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,
    MODE_MULADD = 2'b01,
    MODE_MAC    = 2'b10,
    MODE_CLR    = 2'b11
  } mode_e;

  // Round half up, arithmetic shift by FRAC, clamp to the signed WIDTH range.
  // One guard bit keeps the rounding add from wrapping near full scale.
  function automatic logic [WIDTH-1:0] sat_q(input logic [W2-1:0] r);
    logic signed [W2:0] sum;
    logic signed [W2:0] sh;
    sum = {r[W2-1], r} + RND_C;
    sh  = sum >>> FRAC;
    if (sh > MAX_Q)      sat_q = MAX_Q[WIDTH-1:0];
    else if (sh < MIN_Q) sat_q = MIN_Q[WIDTH-1:0];
    else                 sat_q = sh[WIDTH-1:0];
  endfunction

  logic s1_v_r, s2_v_r, s3_v_r, s4_v_r;
  logic [WIDTH-1:0] s1_a_r, s1_b_r;
  logic [W2-1:0] s1_c_r, s2_c_r, s3_c_r, s4_c_r;
  mode_e s1_mode_r, s2_mode_r, s3_mode_r, s4_mode_r;
  logic [IDW-1:0] s1_id_r, s2_id_r, s3_id_r, s4_id_r;
  logic [W2-1:0] s2_p_r, s3_p_r, s4_p_r, s4_acc_r;
  logic [W2-1:0] acc_mem_r [NUM_ACC];

  logic [W2-1:0] res_mem_r [OUT_DEPTH];
  logic [WIDTH-1:0] q_mem_r [OUT_DEPTH];
  logic [IDW-1:0] id_mem_r [OUT_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic [31:0] perf_r;

  logic accept_s, in_ready_s, push_s, pop_s, out_valid_s, byp_s;
  logic [CW:0] occ_s;
  logic [W2-1:0] prod_s, r_s, wr_val_s, acc_rd_s;
  logic [W2-1:0] a_ext_s, b_ext_s;

  assign inflight  = {2'b00, s1_v_r} + {2'b00, s2_v_r} + {2'b00, s3_v_r} + {2'b00, s4_v_r};
  assign occ_s     = (CW+1)'(inflight) + (CW+1)'(cnt_r);
  // Credit rule: every op in S1..S4 already owns a FIFO slot.
  assign in_ready_s = rst_n && (occ_s < (CW+1)'(OUT_DEPTH));
  assign accept_s   = bus.in_valid && in_ready_s;
  assign bus.in_ready = in_ready_s;
  assign perf_ops   = perf_r;

  assign a_ext_s = {{WIDTH{s1_a_r[WIDTH-1]}}, s1_a_r};
  assign b_ext_s = {{WIDTH{s1_b_r[WIDTH-1]}}, s1_b_r};
  assign prod_s  = a_ext_s * b_ext_s;

  // S4 result selection per mode; all arithmetic wraps at 2*WIDTH bits.
  always_comb begin
    r_s = s4_p_r;
    case (s4_mode_r)
      MODE_MUL:    r_s = s4_p_r;
      MODE_MULADD: r_s = s4_p_r + s4_c_r;
      MODE_MAC:    r_s = s4_acc_r + s4_p_r;
      MODE_CLR:    r_s = s4_acc_r;
      default:     r_s = s4_p_r;
    endcase
  end

  // S3 accumulator read, forwarding S4's pending write for a same-id hazard.
  always_comb begin
    wr_val_s = '0;
    if (s4_mode_r == MODE_MAC) wr_val_s = r_s;
    else                       wr_val_s = '0;
    byp_s = s4_v_r && s3_v_r && s4_mode_r[1] && s3_mode_r[1] && (s4_id_r == s3_id_r);
    if (byp_s) acc_rd_s = wr_val_s;
    else       acc_rd_s = acc_mem_r[s3_id_r];
  end

  // Pipeline stage registers S1..S4.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {s1_v_r, s2_v_r, s3_v_r, s4_v_r} <= 4'b0000;
      s1_a_r <= '0; s1_b_r <= '0;
      s1_c_r <= '0; s2_c_r <= '0; s3_c_r <= '0; s4_c_r <= '0;
      s1_mode_r <= MODE_MUL; s2_mode_r <= MODE_MUL;
      s3_mode_r <= MODE_MUL; s4_mode_r <= MODE_MUL;
      s1_id_r <= '0; s2_id_r <= '0; s3_id_r <= '0; s4_id_r <= '0;
      s2_p_r <= '0; s3_p_r <= '0; s4_p_r <= '0; s4_acc_r <= '0;
    end else begin
      s1_v_r <= accept_s;
      s1_a_r <= bus.in_a; s1_b_r <= bus.in_b; s1_c_r <= bus.in_c;
      s1_mode_r <= mode_e'(bus.in_mode); s1_id_r <= bus.in_id;
      s2_v_r <= s1_v_r; s2_p_r <= prod_s; s2_c_r <= s1_c_r;
      s2_mode_r <= s1_mode_r; s2_id_r <= s1_id_r;
      s3_v_r <= s2_v_r; s3_p_r <= s2_p_r; s3_c_r <= s2_c_r;
      s3_mode_r <= s2_mode_r; s3_id_r <= s2_id_r;
      s4_v_r <= s3_v_r; s4_p_r <= s3_p_r; s4_c_r <= s3_c_r;
      s4_mode_r <= s3_mode_r; s4_id_r <= s3_id_r; s4_acc_r <= acc_rd_s;
    end
  end

  // Accumulator array: cleared on reset, written back by MAC/CLR in S4.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) acc_mem_r[i] <= '0;
    end else if (s4_v_r && s4_mode_r[1]) begin
      acc_mem_r[s4_id_r] <= wr_val_s;
    end
  end

  assign push_s      = s4_v_r;
  assign out_valid_s = (cnt_r != '0);
  assign pop_s       = out_valid_s && bus.out_ready;

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0; rd_ptr_r <= '0; cnt_r <= '0;
    end else begin
      if (push_s) begin
        res_mem_r[wr_ptr_r] <= r_s;
        q_mem_r[wr_ptr_r]   <= sat_q(r_s);
        id_mem_r[wr_ptr_r]  <= s4_id_r;
        wr_ptr_r <= (wr_ptr_r == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_r + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1'b1);
        2'b01:   cnt_r <= cnt_r - CW'(1'b1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // FIFO head presented first-word-fall-through; zeros while empty.
  always_comb begin
    bus.out_valid  = out_valid_s;
    bus.out_result = '0;
    bus.out_q      = '0;
    bus.out_id     = '0;
    if (out_valid_s) begin
      bus.out_result = res_mem_r[rd_ptr_r];
      bus.out_q      = q_mem_r[rd_ptr_r];
      bus.out_id     = id_mem_r[rd_ptr_r];
    end else begin
      bus.out_result = '0;
      bus.out_q      = '0;
      bus.out_id     = '0;
    end
  end

  // Accepted-request counter, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) perf_r <= 32'd0;
    else if (accept_s) perf_r <= perf_r + 32'd1;
    else perf_r <= perf_r;
  end

  dsp_mac_pipe_chk #(.CW(CW), .OUT_DEPTH(OUT_DEPTH)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .cnt   (cnt_r)
  );
endmodule

// Protocol checker: the credit rule must keep every push off a full FIFO.
module dsp_mac_pipe_chk #(
  parameter int CW        = 4,
  parameter int OUT_DEPTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic [CW-1:0] cnt
);
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (cnt < CW'(OUT_DEPTH)))
    else $error("dsp_mac_pipe: result pushed into full output FIFO");
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed self-checking bench for dsp_mac_pipe.
module tb_dsp_mac_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  inflight;
  logic [31:0] perf_ops;
  int chk = 0;
  int pass = 0;

  dsp_mac_pipe_if #(.WIDTH(16), .NUM_ACC(32)) bus ();

  dsp_mac_pipe #(.WIDTH(16), .FRAC(8), .NUM_ACC(32), .OUT_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .inflight(inflight), .perf_ops(perf_ops)
  );

  always #5 clk = ~clk;

  // Present one request from a negedge and hold it until accepted (bounded).
  task automatic issue(input logic [1:0] mode, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] c, input logic [4:0] id, output int stalls);
    stalls = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_mode = mode; bus.in_a = a; bus.in_b = b;
    bus.in_c = c; bus.in_id = id;
    while (!bus.in_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) until the FIFO head is valid.
  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    chk++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); else pass++;
    chk++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else pass++;
    chk++; if (inflight !== 3'd0) $display("FAIL rst_inflight got=%0d exp=0", inflight); else pass++;
    chk++; if (perf_ops !== 32'd0) $display("FAIL rst_perf got=%0d exp=0", perf_ops); else pass++;
    chk++; if (bus.out_result !== 32'd0 || bus.out_q !== 16'd0 || bus.out_id !== 5'd0)
      $display("FAIL rst_outputs got=%h/%h/%h exp=0", bus.out_result, bus.out_q, bus.out_id); else pass++;
    @(negedge clk); rst_n = 1'b1; #1;
    chk++; if (bus.in_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", bus.in_ready); else pass++;
  endtask

  task automatic test_mul_basic();
    int st, cyc;
    bus.out_ready = 1'b1;
    issue(2'b00, 16'h0200, 16'h0180, 32'd0, 5'd1, st);
    wait_out(cyc);
    chk++; if (cyc !== 4) $display("FAIL mul_latency got=%0d exp=4", cyc); else pass++;
    chk++; if (bus.out_result !== 32'h0003_0000) $display("FAIL mul_result got=%h exp=00030000", bus.out_result); else pass++;
    chk++; if (bus.out_q !== 16'h0300) $display("FAIL mul_q got=%h exp=0300", bus.out_q); else pass++;
    chk++; if (bus.out_id !== 5'd1) $display("FAIL mul_id got=%0d exp=1", bus.out_id); else pass++;
    chk++; if (perf_ops !== 32'd1) $display("FAIL mul_perf got=%0d exp=1", perf_ops); else pass++;
    @(posedge clk); #1;
    chk++; if (bus.out_valid !== 1'b0) $display("FAIL mul_pop got=%b exp=0", bus.out_valid); else pass++;
  endtask

  task automatic test_mul_sat();
    int st, cyc;
    issue(2'b00, 16'h7FFF, 16'h7FFF, 32'd0, 5'd2, st);
    wait_out(cyc);
    chk++; if (bus.out_result !== 32'h3FFF_0001) $display("FAIL sat_result got=%h exp=3fff0001", bus.out_result); else pass++;
    chk++; if (bus.out_q !== 16'h7FFF) $display("FAIL sat_q got=%h exp=7fff", bus.out_q); else pass++;
    @(posedge clk); #1;
    issue(2'b00, 16'hFF00, 16'h0100, 32'd0, 5'd4, st);
    wait_out(cyc);
    chk++; if (bus.out_result !== 32'hFFFF_0000) $display("FAIL neg_result got=%h exp=ffff0000", bus.out_result); else pass++;
    chk++; if (bus.out_q !== 16'hFF00) $display("FAIL neg_q got=%h exp=ff00", bus.out_q); else pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int st, tot, cyc;
    logic [31:0] exp_r [5];
    logic [1:0]  md [5];
    exp_r[0] = 32'h0001_0000; exp_r[1] = 32'h0002_0000; exp_r[2] = 32'h0003_0000;
    exp_r[3] = 32'h0003_0000; exp_r[4] = 32'h0001_0000;
    md[0] = 2'b10; md[1] = 2'b10; md[2] = 2'b10; md[3] = 2'b11; md[4] = 2'b10;
    tot = 0;
    for (int i = 0; i < 5; i++) begin
      issue(md[i], 16'h0100, 16'h0100, 32'd0, 5'd3, st);
      tot += st;
    end
    chk++; if (tot !== 0) $display("FAIL b2b_stalls got=%0d exp=0", tot); else pass++;
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      chk++; if (bus.out_valid !== 1'b1 || bus.out_result !== exp_r[i] || bus.out_id !== 5'd3)
        $display("FAIL b2b_result%0d got=%b/%h/%0d exp=1/%h/3", i, bus.out_valid, bus.out_result, bus.out_id, exp_r[i]);
      else pass++;
      if (i == 1) begin
        chk++; if (bus.out_q !== 16'h0200) $display("FAIL b2b_q got=%h exp=0200", bus.out_q); else pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_muladd();
    int st, cyc;
    issue(2'b01, 16'h0100, 16'hFE00, 32'h0001_0000, 5'd7, st);
    wait_out(cyc);
    chk++; if (bus.out_result !== 32'hFFFF_0000) $display("FAIL muladd_result got=%h exp=ffff0000", bus.out_result); else pass++;
    chk++; if (bus.out_q !== 16'hFF00) $display("FAIL muladd_q got=%h exp=ff00", bus.out_q); else pass++;
    chk++; if (bus.out_id !== 5'd7) $display("FAIL muladd_id got=%0d exp=7", bus.out_id); else pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_mode = 2'b00; bus.in_a = 16'(n + 1);
      bus.in_b = 16'h0100; bus.in_c = 32'd0; bus.in_id = 5'(n);
      if (bus.in_ready) n++;
      @(posedge clk);
    end
    #1; bus.in_valid = 1'b0;
    chk++; if (n !== 8) $display("FAIL bp_accepted got=%0d exp=8", n); else pass++;
    chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_low got=%b exp=0", bus.in_ready); else pass++;
    chk++; if (perf_ops !== 32'd8) $display("FAIL bp_perf got=%0d exp=8", perf_ops); else pass++;
    chk++; if (inflight !== 3'd0) $display("FAIL bp_inflight got=%0d exp=0", inflight); else pass++;
    @(negedge clk); bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'((i + 1) * 256) || bus.out_id !== 5'(i))
        $display("FAIL bp_drain%0d got=%b/%h/%0d exp=1/%h/%0d", i, bus.out_valid, bus.out_result, bus.out_id, 32'((i + 1) * 256), i);
      else pass++;
      if (i == 2) begin
        chk++; if (bus.out_q !== 16'h0003) $display("FAIL bp_q got=%h exp=0003", bus.out_q); else pass++;
      end
      @(posedge clk); #1;
      if (i == 0) begin
        chk++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_back got=%b exp=1", bus.in_ready); else pass++;
      end
    end
    chk++; if (bus.out_valid !== 1'b0) $display("FAIL bp_empty got=%b exp=0", bus.out_valid); else pass++;
  endtask

  task automatic test_reset_midflight();
    int st, cyc;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(2'b10, 16'h0100, 16'h0100, 32'd0, 5'd3, st);
    @(posedge clk); #1;
    chk++; if (inflight !== 3'd3) $display("FAIL mid_inflight got=%0d exp=3", inflight); else pass++;
    chk++; if (bus.out_valid !== 1'b1) $display("FAIL mid_fifo got=%b exp=1", bus.out_valid); else pass++;
    @(negedge clk); rst_n = 1'b0; #1;
    chk++; if (bus.in_ready !== 1'b0) $display("FAIL mid_ready_in_rst got=%b exp=0", bus.in_ready); else pass++;
    @(posedge clk); #1;
    chk++; if (bus.out_valid !== 1'b0 || inflight !== 3'd0 || perf_ops !== 32'd0 || bus.out_result !== 32'd0)
      $display("FAIL mid_rst_state got=%b/%0d/%0d/%h exp=0/0/0/0", bus.out_valid, inflight, perf_ops, bus.out_result);
    else pass++;
    @(negedge clk); rst_n = 1'b1; bus.out_ready = 1'b1;
    issue(2'b10, 16'h0100, 16'h0100, 32'd0, 5'd3, st);
    wait_out(cyc);
    chk++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0001_0000)
      $display("FAIL mid_acc_cleared got=%b/%h exp=1/00010000", bus.out_valid, bus.out_result);
    else pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_a = 16'd0; bus.in_b = 16'd0; bus.in_c = 32'd0;
    bus.in_mode = 2'b00; bus.in_id = 5'd0; bus.out_ready = 1'b0;
    test_reset();
    test_mul_basic();
    test_mul_sat();
    test_back_to_back();
    test_muladd();
    test_backpressure();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
Second-generation MAC engine for the MobileNetV3 accelerator datapath; successor to the single-request round-robin DSP manager.
- Fully pipelined: accepts one signed fixed-point request per cycle under valid/ready.
- Four modes: MUL, MULADD, per-ID accumulate, accumulator clear.
- Returns results in order through an output FIFO with credit-based backpressure, so no request is ever dropped.
- Sits between the conv/depthwise schedulers and the post-processing (bias/activation) stage.

Parameters:
WIDTH, 16, operand width (signed two's complement)
FRAC, 8, fractional bits of Q-format operands and res_q
NUM_ACC, 32, number of accumulator entries; ID width is clog2(NUM_ACC)
OUT_DEPTH, 8, output FIFO depth; must be >= 4

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_a  in  WIDTH  signed multiplicand
in_b  in  WIDTH  signed multiplier
in_c  in  2*WIDTH  signed addend (MULADD only)
in_mode  in  2  00 MUL, 01 MULADD, 10 MAC, 11 CLR
in_id  in  clog2(NUM_ACC)  tag; accumulator index for MAC/CLR
out_valid  out  1  result valid at FIFO head
out_ready  in  1  consumer pop
out_result  out  2*WIDTH  raw signed result
out_q  out  WIDTH  rounded, saturated Q-format result
out_id  out  clog2(NUM_ACC)  tag of result
inflight  out  3  ops in S1..S4
perf_ops  out  32  accepted-request counter, wraps

Behaviour:
Interface rules:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset (rst_n=0 at posedge): pipeline valids cleared, in-flight ops discarded, FIFO emptied, all NUM_ACC accumulators = 0, perf_ops = 0, out_valid = 0, out_result/out_q/out_id = 0, inflight = 0.
- in_ready is forced 0 while rst_n = 0 and applies equally mid-operation.
- in_ready = (inflight + fifo_count < OUT_DEPTH). It does not depend on in_valid or any request field.

Pipeline (accept at cycle t):
- S1 (t+1): register operands, mode, id.
- S2 (t+2): signed product p = a*b, 2*WIDTH bits, exact.
- S3 (t+3): read acc[id] for MAC/CLR.
- S4 (t+4): compute and write.
  - MUL: r = p.
  - MULADD: r = p + c.
  - MAC: r = acc + p, written back to acc[id].
  - CLR: r = old acc, acc[id] <= 0.
- Result pushed into FIFO at end of S4.
- out_valid rises at t+4 if FIFO was empty (first-word-fall-through).
- Minimum latency is 4 cycles; throughput is 1 op/cycle.

Arithmetic and ordering:
- All arithmetic wraps modulo 2^(2*WIDTH); accumulators are 2*WIDTH bits.
- Hazard bypass: if S4 holds MAC/CLR with the same id as a MAC/CLR in S3, S3 uses S4's write value (r for MAC, 0 for CLR) instead of the array read. Back-to-back same-id MACs run at full rate with no stall.
- out_q = saturate_WIDTH((out_result + 2^(FRAC-1)) >>> FRAC), round-half-up, arithmetic shift, clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. FRAC = 0 means no rounding add.
- Results leave in acceptance order; out_id echoes in_id for every mode.

FIFO and counters:
- FIFO pop when out_valid && out_ready. Simultaneous push and pop at any occupancy is legal; count is unchanged.
- The credit rule guarantees no push ever finds the FIFO full. A push to a full FIFO is a design error; flag with assertion.
- inflight = number of valid stages S1..S4 (0..4).
- perf_ops increments on each accepted request.

Test Plan:
1. MUL, in_a=0x0200, in_b=0x0180, id=1, out_ready=1 -> 4 cycles later out_result=0x00030000, out_q=0x0300, out_id=1.
2. MUL 0x7FFF*0x7FFF -> out_result=0x3FFF0001, out_q=0x7FFF (saturated). MUL 0xFF00*0x0100 -> out_result=0xFFFF0000, out_q=0xFF00.
3. Three back-to-back MACs id=3, a=b=0x0100 -> results 0x10000, 0x20000, 0x30000 on consecutive cycles, no in_ready drop (bypass). Then CLR id=3 -> out_result=0x30000; next MAC id=3 -> 0x10000.
4. MULADD a=0x0100, b=0xFE00, c=0x00010000 -> out_result=0xFFFF0000 (-0x20000+0x10000), out_q=0xFF00.
5. Hold out_ready=0, stream in_valid=1 -> exactly OUT_DEPTH=8 requests accepted, in_ready=0 thereafter. Release out_ready -> 8 results in order, in_ready reasserts, no loss, perf_ops=8.
6. Reset with 3 ops in flight and 2 in FIFO -> next cycle out_valid=0, inflight=0, perf_ops=0; subsequent MAC id=3 returns 0x10000 (accumulators cleared).
